edge_row_packer: RTL and testbench
==================================

# edge_row_packer

Downstream of the CANNY edge core. Collects the serial 1-bit `edge_out` stream, qualified by `readable`, into 18-bit row words, 18 rows per 20×20 input tile (324 bits). Completed rows go into a small FIFO and leave on a valid/ready port, so a slower consumer (memory writer or bus bridge) can stall without stalling the core. The core cannot be back-pressured, so FIFO overrun is detected and flagged rather than prevented.

## Interface
- `ROW_W`, 18, bits per output row (edge columns per tile)
- `ROWS`, 18, rows per tile
- `FIFO_DEPTH`, 4, row-word FIFO entries; power of 2, ≥2

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `edge_in`  in  1  edge bit from the core's `edge_out`
- `readable`  in  1  `edge_in` valid this cycle
- `out_data`  out  ROW_W  row word; bit 0 = column 0 (first bit received)
- `out_row`  out  5  row index 0..ROWS-1 of `out_data`
- `out_last`  out  1  high with the last row of a tile (`out_row`==ROWS-1)
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `overflow`  out  1  sticky: a completed row was dropped

## Operation
- Column counter `col` (0..ROW_W-1), row counter `row` (0..ROWS-1), ROW_W-bit assembly register.
- Cycle with `readable`=1: bit `col` of the assembly register ← `edge_in`; `col`++.
- Cycle with `readable`=1 and `col`==ROW_W-1 (row complete):
  - push {assembled bits with the incoming bit as bit ROW_W-1, `row`, `row`==ROWS-1} to the FIFO
  - `col`←0
  - `row`←`row`+1, wrapping ROWS-1→0
- Tile boundaries come only from the counter wrap. No per-tile reset is needed, and this block does not take the core's per-tile reset.
- Cycles with `readable`=0: counters and assembly register hold. Gaps of any length within a row or between rows are legal.
- FIFO pop: `out_valid`&&`out_ready` at the clock edge.
- Push while full:
  - with a pop in the same cycle: accepted, count unchanged
  - with no pop: row dropped, `overflow`←1, counters still advance. Later rows keep their correct `out_row`.
- `overflow` stays 1 until `reset`.
- `reset`: `col`=0, `row`=0, FIFO emptied, undrained rows discarded, `overflow`=0. Applies mid-row and mid-tile; the next bit after reset is row 0, column 0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0, `overflow`=0.
- Latency: row completes on edge N, so `out_valid`=1 with that row after edge N, available to the consumer in cycle N+1. The FIFO has no combinational push→pop bypass.
- While `out_valid`&&!`out_ready`: `out_data`, `out_row`, `out_last` are held stable.
- `out_valid` never drops without a pop or a reset.
- `out_data`/`out_row`/`out_last` are registered FIFO-head outputs with no combinational path from `edge_in`/`readable`.
- When empty, `out_data`/`out_row`/`out_last` keep their last values, or 0 after reset. Consumers ignore them.
- Throughput: 1 row per ROW_W `readable` cycles. With `out_ready` held high, occupancy never exceeds 1.
- `overflow` asserts after the edge on which the drop occurs.

## Test plan
- Reset, `out_ready`=1, then 324 consecutive `readable` bits with bit k = (k mod 3 == 0) → 18 words, each 0x09249 (bit c set for c mod 3==0; 18 mod 3==0 so every row starts at phase 0), `out_row` 0..17, `out_last` only on row 17, each word valid 1 cycle after its 18th bit, `overflow`=0.
- Same stream with `readable` randomly low ~50% of cycles → identical words and order. No word appears before its 18th qualified bit.
- `out_ready`=0 for the whole tile, FIFO_DEPTH=4 → rows 0–3 held with head stable at row 0, `overflow`=1 after row 4 completes. After `out_ready`=1, exactly rows 0,1,2,3 are delivered.
- FIFO full with the row-completing bit arriving on a cycle with `out_ready`=1 → no drop, `overflow` stays 0, count stays 4.
- `reset` pulsed after 100 bits (mid row 5), 2 rows undrained → `out_valid`=0 next cycle. A fresh 324-bit tile then yields rows 0..17 correctly.
- Two back-to-back tiles with no reset, second tile all ones → rows 0..17 of 0x00000 then rows 0..17 of 0x3FFFF, `out_last` twice.

Source files
------------

// File: rtl/edge_row_packer.sv
// edge_row_packer
// Packs the serial edge-bit stream from the CANNY core into ROW_W-bit row
// words (ROWS rows per tile) and queues them in a small FIFO drained over a
// valid/ready port. The core cannot be stalled, so a row completing while
// the FIFO is full (and not popping) is dropped and flagged in `overflow`.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears counters, FIFO, overflow
//   edge_in    edge bit from the core
//   readable   edge_in is valid this cycle
//   out_data   row word, bit 0 = first column received
//   out_row    row index of out_data within its tile
//   out_last   out_data is the last row of a tile
//   out_valid  FIFO head valid
//   out_ready  consumer accepts the head this cycle
//   overflow   sticky: a completed row was dropped
module edge_row_packer #(
  parameter int ROW_W      = 18,
  parameter int ROWS       = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             edge_in,
  input  logic             readable,
  output logic [ROW_W-1:0] out_data,
  output logic [4:0]       out_row,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int CW = $clog2(ROW_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  // FIFO entry layout: {last, row[4:0], data[ROW_W-1:0]}
  localparam int EW = ROW_W + 6;

  logic [CW-1:0]                  col_q, col_d;
  logic [4:0]                     row_q, row_d;
  logic [ROW_W-1:0]               asm_q, asm_d;
  logic [FIFO_DEPTH-1:0][EW-1:0]  mem_q, mem_d;
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]                  cnt_q, cnt_d;
  logic [EW-1:0]                  head_q, head_d;
  logic                           ovf_q, ovf_d;

  logic          row_done, pop, full, accept;
  logic [EW-1:0] push_entry;
  logic [NW-1:0] rem;

  always_comb begin
    row_done   = readable && (col_q == CW'(ROW_W - 1));
    // The completing bit goes straight into the top of the word; the
    // assembly register only ever holds the first ROW_W-1 bits.
    push_entry = {(row_q == 5'(ROWS - 1)), row_q, edge_in, asm_q[ROW_W-2:0]};
    pop        = (cnt_q != '0) && out_ready;
    full       = (cnt_q == NW'(FIFO_DEPTH));
    // A push into a full FIFO still lands if the head leaves on the same edge.
    accept     = row_done && (!full || pop);

    col_d    = col_q;
    row_d    = row_q;
    asm_d    = asm_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    ovf_d    = ovf_q;

    if (readable) begin
      asm_d[col_q] = edge_in;
      if (row_done) begin
        col_d = '0;
        row_d = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (accept) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (row_done && !accept) ovf_d = 1'b1;

    rem   = cnt_q - {{(NW-1){1'b0}}, pop};
    cnt_d = rem + {{(NW-1){1'b0}}, accept};

    // Head register tracks whatever sits at the read pointer after this
    // edge. If nothing survives the pop, the incoming row becomes the head.
    // When empty it simply keeps its previous contents.
    if (cnt_d != '0) begin
      if (rem == '0) head_d = push_entry;
      else           head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      asm_q    <= '0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      asm_q    <= asm_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_data  = head_q[ROW_W-1:0];
  assign out_row   = head_q[ROW_W+4:ROW_W];
  assign out_last  = head_q[EW-1];
  assign out_valid = (cnt_q != '0);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_edge_row_packer.sv
module tb_edge_row_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        edge_in = 1'b0;
  logic        readable = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] out_data;
  logic [4:0]  out_row;
  logic        out_last;
  logic        out_valid;
  logic        overflow;

  edge_row_packer #(.ROW_W(18), .ROWS(18), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .edge_in(edge_in), .readable(readable),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] d;
    logic [4:0]  r;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          npop = 0;
  int          nlast = 0;
  logic [17:0] last_data = '0;
  logic [4:0]  last_row = '0;
  logic [17:0] m_word = '0;
  int          m_col = 0;
  int          m_row = 0;
  logic        exp_ovf = 1'b0;

  // Scoreboard side: any valid head must match the oldest expected row;
  // checked every cycle so a stalled head that changes is also caught.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got row=%0d data=%05h, expected no word", out_row, out_data);
      end else begin
        if ({out_data, out_row, out_last} !== sb[0]) begin
          fails++;
          $display("FAIL head_word: got data=%05h row=%0d last=%0b, expected data=%05h row=%0d last=%0b",
                   out_data, out_row, out_last, sb[0].d, sb[0].r, sb[0].l);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          npop++;
          if (out_last) nlast++;
          last_data = out_data;
          last_row  = out_row;
        end
      end
    end
  end

  function automatic logic bit_of(input int pat, input int k);
    case (pat)
      0:       return (k % 3 == 0);
      1:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // One clock: drive inputs, update the reference model, then check
  // out_valid/overflow just after the edge.
  task automatic step(input logic b, input logic rd);
    logic pop_m;
    exp_t e;
    pop_m    = (sb.size() > 0) && out_ready;
    edge_in  = b;
    readable = rd;
    if (rd) begin
      m_word[m_col] = b;
      if (m_col == 17) begin
        e.d = m_word;
        e.r = m_row[4:0];
        e.l = (m_row == 17);
        if (sb.size() < 4 || pop_m) sb.push_back(e);
        else exp_ovf = 1'b1;
        m_col = 0;
        m_row = (m_row == 17) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk); #1;
    readable = 1'b0;
    tests++;
    if (out_valid !== (sb.size() != 0)) begin
      fails++;
      $display("FAIL out_valid: got %0b, expected %0b", out_valid, sb.size() != 0);
    end
    tests++;
    if (overflow !== exp_ovf) begin
      fails++;
      $display("FAIL overflow: got %0b, expected %0b", overflow, exp_ovf);
    end
  endtask

  task automatic send(input int k0, input int n, input int pat, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) while ($urandom_range(99, 0) < 50) step(1'($urandom_range(1, 0)), 1'b0);
      step(bit_of(pat, k0 + k), 1'b1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    readable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    m_col = 0;
    m_row = 0;
    m_word = '0;
    exp_ovf = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1'b0, 1'b0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d words still pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (out_valid !== 1'b0 || out_data !== 18'h0 || out_row !== 5'd0 ||
        out_last !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got valid=%0b data=%05h row=%0d last=%0b ovf=%0b, expected all 0",
               out_valid, out_data, out_row, out_last, overflow);
    end
  endtask

  task automatic test_basic(input bit gaps);
    int p0, l0;
    do_reset();
    out_ready = 1'b1;
    p0 = npop; l0 = nlast;
    send(0, 324, 0, gaps);
    drain();
    tests++;
    if (npop - p0 != 18 || nlast - l0 != 1) begin
      fails++;
      $display("FAIL tile_count: got %0d words %0d last, expected 18 words 1 last", npop - p0, nlast - l0);
    end
    tests++;
    if (last_data !== 18'h09249 || last_row !== 5'd17) begin
      fails++;
      $display("FAIL tile_last_word: got data=%05h row=%0d, expected data=09249 row=17", last_data, last_row);
    end
  endtask

  task automatic test_overflow();
    int p0;
    do_reset();
    out_ready = 1'b0;
    p0 = npop;
    send(0, 90, 0, 1'b0);
    tests++;
    if (overflow !== 1'b1 || out_row !== 5'd0) begin
      fails++;
      $display("FAIL overflow_after_row4: got ovf=%0b head_row=%0d, expected ovf=1 head_row=0", overflow, out_row);
    end
    send(90, 234, 0, 1'b0);
    drain();
    tests++;
    if (npop - p0 != 4 || last_row !== 5'd3) begin
      fails++;
      $display("FAIL overflow_delivered: got %0d words last_row=%0d, expected 4 words last_row=3", npop - p0, last_row);
    end
  endtask

  task automatic test_full_pop_same_cycle();
    int p0;
    do_reset();
    out_ready = 1'b0;
    p0 = npop;
    send(0, 72 + 17, 0, 1'b0);
    out_ready = 1'b1;
    send(89, 1, 0, 1'b0);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_no_drop: got ovf=%0b, expected 0", overflow);
    end
    drain();
    tests++;
    if (npop - p0 != 5 || last_row !== 5'd4) begin
      fails++;
      $display("FAIL full_pop_delivered: got %0d words last_row=%0d, expected 5 words last_row=4", npop - p0, last_row);
    end
  endtask

  task automatic test_mid_reset();
    int p0;
    do_reset();
    out_ready = 1'b1;
    send(0, 64, 0, 1'b0);
    out_ready = 1'b0;
    send(64, 36, 0, 1'b0);
    tests++;
    if (out_valid !== 1'b1 || out_row !== 5'd3) begin
      fails++;
      $display("FAIL pre_reset_pending: got valid=%0b row=%0d, expected valid=1 row=3", out_valid, out_row);
    end
    do_reset();
    tests++;
    if (out_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_flush: got valid=%0b ovf=%0b, expected 0 0", out_valid, overflow);
    end
    out_ready = 1'b1;
    p0 = npop;
    send(0, 324, 0, 1'b0);
    drain();
    tests++;
    if (npop - p0 != 18 || last_row !== 5'd17 || last_data !== 18'h09249) begin
      fails++;
      $display("FAIL after_reset_tile: got %0d words row=%0d data=%05h, expected 18 words row=17 data=09249",
               npop - p0, last_row, last_data);
    end
  endtask

  task automatic test_back_to_back();
    int p0, l0;
    do_reset();
    out_ready = 1'b1;
    p0 = npop; l0 = nlast;
    send(0, 324, 1, 1'b0);
    send(0, 324, 2, 1'b0);
    drain();
    tests++;
    if (npop - p0 != 36 || nlast - l0 != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d words %0d last, expected 36 words 2 last", npop - p0, nlast - l0);
    end
    tests++;
    if (last_data !== 18'h3FFFF || last_row !== 5'd17) begin
      fails++;
      $display("FAIL b2b_last_word: got data=%05h row=%0d, expected data=3ffff row=17", last_data, last_row);
    end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_overflow();
    test_full_pop_same_cycle();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
